// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC SPI writer: the frame-sequencer state
// encoding, the default command nibble and the SPI frame length.
// -----------------------------------------------------------------------------
package dac_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      SHIFT_LO,
      RECOVER
   } state_t;

   // Write-and-update, channel A.
   localparam logic [3:0] DEF_CMD = 4'b0011;

   // 4 command bits followed by 12 data bits.
   localparam int FRAME_BITS = 16;

endpackage

// File: rtl/dac_spi_writer_clk_div_tick.sv
// -----------------------------------------------------------------------------
// clk_div_tick
// Down-counter that emits a one-cycle tick on the DIV-th clock of each
// period. Pulsing `restart` reloads the counter, so the first tick after a
// restart lands exactly DIV cycles after the restart edge.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   restart  in   reload the counter (asserted on the cycle before a new state)
//   tick     out  high on the last cycle of each DIV-cycle period
// -----------------------------------------------------------------------------
module clk_div_tick #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= LOAD;
      end else if (restart || (cnt == '0)) begin
         cnt <= LOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/dac_spi_writer.sv
// -----------------------------------------------------------------------------
// dac_spi_writer
// Serialises the PID control word to a 12-bit SPI DAC. A rising edge on
// `start` latches `din`; the word goes out as a 16-bit frame {CMD, data},
// MSB first, SPI mode 0 (CPOL=0, data changes on SCLK falling edge).
// Requests arriving while a frame is in flight are collapsed into a single
// pending word (latest wins) and served after the CS_HIGH recovery gap.
//
// Build option: define DAC_CLAMP_EN to treat `din` as two's complement and
// saturate it into the DAC range (negative -> 0, above full scale -> full
// scale). Without it the upper input bits are simply dropped.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   start  in   request level; a rising edge requests a frame
//   din    in   control word [DIN_W-1:0]
//   sclk   out  SPI clock, idles low
//   mosi   out  SPI data, MSB first
//   cs_n   out  DAC chip select, active low
//   busy   out  frame in progress or in recovery gap
//   done   out  one-cycle pulse as cs_n rises at the end of a frame
// -----------------------------------------------------------------------------
module dac_spi_writer
   import dac_pkg::*;
#(
   parameter int         DIN_W   = 13,
   parameter int         DAC_W   = 12,
   parameter logic [3:0] CMD     = DEF_CMD,
   parameter int         CLK_DIV = 4,
   parameter int         CS_HIGH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [DIN_W-1:0] din,
   output logic             sclk,
   output logic             mosi,
   output logic             cs_n,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = $clog2(FRAME_BITS + 1);
   localparam int REC_W = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
   localparam logic [BIT_W-1:0] BITS_ALL  = BIT_W'(FRAME_BITS);
   localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [REC_W-1:0] REC_LOAD  = REC_W'(CS_HIGH - 1);

   state_t state, state_next;

   logic [1:0]            ss;          // start synchroniser / edge detector
   logic                  start_edge;
   logic                  tick;
   logic                  restart;
   logic [BIT_W-1:0]      bit_cnt;     // bits whose SCLK rising edge has occurred
   logic [FRAME_BITS-2:0] rest;        // bits still to be presented on mosi
   logic                  pending;
   logic [DIN_W-1:0]      pend_word;
   logic [REC_W-1:0]      rec_cnt;
   logic                  rec_last;
   logic                  load_frame;
   logic [DIN_W-1:0]      load_word;
   logic [DAC_W-1:0]      load_data;
   logic [FRAME_BITS-1:0] frame;

   assign start_edge = ss[0] & ~ss[1];
   assign rec_last   = (rec_cnt == '0);

   // Every state change reloads the half-period divider.
   assign restart = (state_next != state);

   clk_div_tick #(
      .DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   // A new frame starts either from IDLE or straight out of RECOVER. An edge
   // seen on the RECOVER exit cycle is newer than any stored pending word.
   assign load_frame = ((state == IDLE) && start_edge) ||
                       ((state == RECOVER) && rec_last && (pending || start_edge));
   assign load_word  = start_edge ? din : pend_word;

`ifdef DAC_CLAMP_EN
   localparam logic [DAC_W-1:0] DAC_MAX = '1;

   always_comb begin
      if (load_word[DIN_W-1]) begin
         load_data = '0;
      end else if (load_word > DIN_W'(DAC_MAX)) begin
         load_data = DAC_MAX;
      end else begin
         load_data = load_word[DAC_W-1:0];
      end
   end
`else
   // Upper bits wrap away; fold them into a sink so they are visibly dropped.
   logic unused_hi;
   assign unused_hi = ^load_word[DIN_W-1:DAC_W];
   assign load_data = load_word[DAC_W-1:0];
`endif

   assign frame = {CMD, load_data};

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // --------------------------------------------------------------- next state
   // NOTE: default the combinational result first so no path leaves it
   // unassigned and a latch cannot be inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (start_edge) state_next = SETUP;
         SETUP:    if (tick)       state_next = SHIFT_HI;
         SHIFT_HI: if (tick)       state_next = SHIFT_LO;
         SHIFT_LO: if (tick)       state_next = (bit_cnt == BITS_ALL) ? RECOVER : SHIFT_HI;
         RECOVER:  if (rec_last)   state_next = load_frame ? SETUP : IDLE;
         default:                  state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      cs_n = 1'b1;
      sclk = 1'b0;
      busy = 1'b1;
      done = 1'b0;
      case (state)
         IDLE:     busy = 1'b0;
         SETUP:    cs_n = 1'b0;
         SHIFT_HI: begin
            cs_n = 1'b0;
            sclk = 1'b1;
         end
         SHIFT_LO: cs_n = 1'b0;
         // First recovery cycle is the cycle cs_n has just risen.
         RECOVER:  done = (rec_cnt == REC_LOAD);
         default:  busy = 1'b0;
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ss        <= 2'b00;
         rest      <= '0;
         mosi      <= 1'b0;
         bit_cnt   <= '0;
         pending   <= 1'b0;
         pend_word <= '0;
         rec_cnt   <= '0;
      end else begin
         ss <= {ss[0], start};

         if (load_frame) begin
            rest    <= frame[FRAME_BITS-2:0];
            mosi    <= frame[FRAME_BITS-1];
            bit_cnt <= '0;
            pending <= 1'b0;
         end else begin
            if (start_edge && (state != IDLE)) begin
               pending   <= 1'b1;
               pend_word <= din;
            end
            // Leaving the high phase: the DAC has sampled this bit, present
            // the next one. After the final bit mosi simply holds.
            if ((state == SHIFT_HI) && tick) begin
               bit_cnt <= bit_cnt + BIT_W'(1);
               if (bit_cnt != BITS_LAST) begin
                  mosi <= rest[FRAME_BITS-2];
                  rest <= {rest[FRAME_BITS-3:0], 1'b0};
               end
            end
         end

         if ((state != RECOVER) && (state_next == RECOVER)) begin
            rec_cnt <= REC_LOAD;
         end else if ((state == RECOVER) && !rec_last) begin
            rec_cnt <= rec_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dac_spi_writer.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_writer
// Directed bench for dac_spi_writer at default parameters (CLK_DIV=4,
// CS_HIGH=8). A negedge monitor records every cs_n-low window (bits sampled
// on SCLK rising edges, cs_n-low length, SCLK rising-edge count, preceding
// cs_n-high gap, done at cs_n rise); the main sequence drives requests and
// compares the records against hand-computed frames.
// -----------------------------------------------------------------------------
module tb_dac_spi_writer;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [12:0] din   = '0;
   logic        sclk, mosi, cs_n, busy, done;

   int tests = 0;
   int fails = 0;

   dac_spi_writer dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .din   (din),
      .sclk  (sclk),
      .mosi  (mosi),
      .cs_n  (cs_n),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- monitor
   int          cyc        = 0;
   int          hi_run     = 0;
   int          cur_low    = 0;
   int          cur_rises  = 0;
   int          cur_gap    = 0;
   int          rise_cyc   = 0;
   int          fall_delay = 0;
   int          done_cnt   = 0;
   int          busy_low   = 0;
   int          n_frames   = 0;
   logic [15:0] cur_bits   = '0;
   logic        prev_cs    = 1'b1;
   logic        prev_sclk  = 1'b0;
   logic        prev_busy  = 1'b0;

   logic [15:0] f_bits  [32];
   int          f_low   [32];
   int          f_rises [32];
   int          f_gap   [32];
   logic        f_done  [32];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (prev_cs && !cs_n) begin
         cur_low   <= 1;
         cur_rises <= 0;
         cur_bits  <= '0;
         cur_gap   <= hi_run;
      end else if (!cs_n) begin
         cur_low <= cur_low + 1;
         if (sclk && !prev_sclk) begin
            cur_bits  <= {cur_bits[14:0], mosi};
            cur_rises <= cur_rises + 1;
         end
      end
      if (!prev_cs && cs_n && (n_frames < 32)) begin
         f_bits[n_frames]  <= cur_bits;
         f_low[n_frames]   <= cur_low;
         f_rises[n_frames] <= cur_rises;
         f_gap[n_frames]   <= cur_gap;
         f_done[n_frames]  <= done;
         n_frames          <= n_frames + 1;
         rise_cyc          <= cyc;
      end
      hi_run <= cs_n ? hi_run + 1 : 0;
      if (done) done_cnt <= done_cnt + 1;
      if (!busy) busy_low <= busy_low + 1;
      if (prev_busy && !busy) fall_delay <= cyc - rise_cyc;
      prev_cs   <= cs_n;
      prev_sclk <= sclk;
      prev_busy <= busy;
   end

   // ----------------------------------------------------------------- helpers
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_frames(input string tag, input int target, input int budget);
      int k = 0;
      while ((n_frames < target) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      check(tag, n_frames, target);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      @(negedge clk);
      while ((done !== 1'b1) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      check(tag, done, 1'b1);
   endtask

   // ---------------------------------------------------------------- sequence
   int n0, d0, b0;
   logic [15:0] clamp_exp;

   initial begin
      // Reset state.
      #12;
      check("rst_sclk", sclk, 1'b0);
      check("rst_mosi", mosi, 1'b0);
      check("rst_cs_n", cs_n, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      // Basic frame: 13'h0A5C -> {0011, A5C}.
      n0 = n_frames;
      d0 = done_cnt;
      din   = 13'h0A5C;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_frames("basic_wait", n0 + 1, 400);
      repeat (15) @(negedge clk);
      check("basic_bits",  f_bits[n0],  16'h3A5C);
      check("basic_low",   f_low[n0],   132);
      check("basic_rises", f_rises[n0], 16);
      check("basic_done",  f_done[n0],  1'b1);
      check("basic_ndone", done_cnt - d0, 1);
      check("basic_busy_fall", fall_delay, 8);

      // Held start: one frame for a 500-cycle level.
      n0 = n_frames;
      din   = 13'h0123;
      start = 1'b1;
      repeat (500) @(negedge clk);
      check("held_count", n_frames - n0, 1);
      check("held_bits",  f_bits[n0], 16'h3123);
      start = 1'b0;
      repeat (5) @(negedge clk);

      // Back-to-back: three edges inside one frame, only the last is kept.
      n0 = n_frames;
      din   = 13'h0100;
      start = 1'b1;
      repeat (5) @(negedge clk);
      b0 = busy_low;
      repeat (5) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      din   = 13'h0200;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      din   = 13'h0300;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_frames("b2b_wait", n0 + 2, 600);
      check("b2b_busy_held", busy_low - b0, 0);
      check("b2b_bits_a", f_bits[n0],     16'h3100);
      check("b2b_bits_b", f_bits[n0 + 1], 16'h3300);
      check("b2b_gap",    f_gap[n0 + 1],  8);
      check("b2b_low_b",  f_low[n0 + 1],  132);
      repeat (300) @(negedge clk);
      check("b2b_no_extra", n_frames - n0, 2);

      // Edge landing on the RECOVER exit cycle.
      n0 = n_frames;
      din   = 13'h0456;
      start = 1'b1;
      wait_done("rx_done_wait", 400);
      start = 1'b0;
      repeat (6) @(negedge clk);
      din   = 13'h0789;
      start = 1'b1;
      wait_frames("rx_wait", n0 + 2, 400);
      start = 1'b0;
      check("rx_bits_a", f_bits[n0],     16'h3456);
      check("rx_bits_b", f_bits[n0 + 1], 16'h3789);
      check("rx_gap",    f_gap[n0 + 1],  8);
      repeat (20) @(negedge clk);

      // Reset asserted in the middle of bit 7.
      n0 = n_frames;
      d0 = done_cnt;
      din   = 13'h0ABC;
      start = 1'b1;
      begin
         int k = 0;
         while (!((cur_rises == 8) && (sclk === 1'b1)) && (k < 400)) begin
            @(negedge clk);
            k++;
         end
      end
      check("mid_reached", cur_rises, 8);
      #2 reset = 1'b0;
      #1;
      check("mid_cs_n", cs_n, 1'b1);
      check("mid_sclk", sclk, 1'b0);
      check("mid_busy", busy, 1'b0);
      check("mid_done", done, 1'b0);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("mid_abort_rec",   n_frames - n0, 1);
      check("mid_abort_done",  f_done[n0], 1'b0);
      check("mid_abort_rises", f_rises[n0], 8);
      check("mid_no_done",     done_cnt - d0, 0);

      n0 = n_frames;
      din   = 13'h0DEF;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_frames("post_wait", n0 + 1, 400);
      check("post_bits",  f_bits[n0],  16'h3DEF);
      check("post_low",   f_low[n0],   132);
      check("post_rises", f_rises[n0], 16);
      check("post_done",  f_done[n0],  1'b1);
      repeat (15) @(negedge clk);

      // Negative input: clamps to zero, or wraps to F00 without clamping.
`ifdef DAC_CLAMP_EN
      clamp_exp = 16'h3000;
`else
      clamp_exp = 16'h3F00;
`endif
      n0 = n_frames;
      din   = 13'h1F00;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_frames("neg_wait", n0 + 1, 400);
      check("neg_bits", f_bits[n0], clamp_exp);
      repeat (15) @(negedge clk);

      // Full-scale positive input passes unchanged in either build.
      n0 = n_frames;
      din   = 13'h0FFF;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_frames("fs_wait", n0 + 1, 400);
      check("fs_bits", f_bits[n0], 16'h3FFF);
      repeat (15) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
